// File: rtl/output_drain_axis_if.sv
// output_drain_axis_if: AXI-Stream bundle carried from the
// output drain to the S2MM DMA.
interface output_drain_axis_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/output_drain_axis.sv
// output_drain_axis: drains the banked output BRAM array to an
// AXI-Stream master, address-major, with optional ReLU.
module output_drain_axis #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH:0]             num_words,
    input  logic                            relu_en,
    output logic                            ext_read_mode,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
    output logic [NUM_BRAMS-1:0]            ext_read_en,
    input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
    output_drain_axis_if.master             m_axis,
    output logic                            busy,
    output logic                            done
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int BW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
    localparam int LW = NUM_BRAMS * DW;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [CW-1:0] n_q, rd_cnt_q, line_cnt_q;
    logic [BW-1:0] beat_q;
    logic [LW-1:0] line_q, pf_q;
    logic          relu_q, pend_q, line_full_q, pf_full_q, done_q;

    logic                  run, hs, line_end, tlast_w, final_hs;
    logic                  pf_move, line_free, issue;
    logic                  launch, zero_start;
    logic [CW-1:0]         n_clamp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         word;

    assign n_clamp = (num_words > CW'(DEPTH)) ? CW'(DEPTH) : num_words;

    assign run      = (state_q == RUN);
    assign hs       = line_full_q & m_axis.tready;
    assign line_end = hs & (beat_q == BW'(NUM_BRAMS - 1));
    assign tlast_w  = line_full_q
                    & (beat_q == BW'(NUM_BRAMS - 1))
                    & (line_cnt_q == n_q - CW'(1));
    assign final_hs = hs & tlast_w;

    // A full prefetch line slides into the line buffer as the
    // last beat of the current line leaves, so tvalid never drops.
    assign pf_move   = line_end & pf_full_q;
    assign line_free = ~line_full_q | (line_end & ~pf_full_q);
    assign issue     = run & (rd_cnt_q < n_q) & ~pend_q
                     & (~pf_full_q | pf_move);

    assign addr = issue ? rd_cnt_q[ADDR_WIDTH-1:0]
                        : rd_cnt_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    assign ext_read_mode      = run;
    assign ext_read_en        = {NUM_BRAMS{issue}};
    assign ext_read_addr_flat = run ? {NUM_BRAMS{addr}} : '0;
    assign busy               = run;
    assign done               = done_q;

    assign word          = line_q[int'(beat_q) * DW +: DW];
    assign m_axis.tvalid = line_full_q;
    assign m_axis.tlast  = tlast_w;
    assign m_axis.tdata  = ~line_full_q ? '0
                         : (relu_q && word[DW-1]) ? '0 : word;

    // Next state and run-launch decode.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        zero_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_clamp == '0) begin
                        zero_start = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= zero_start | (run & final_hs);
        end
    end

    // Read issue, capture, line transfer and beat sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= '0;
            relu_q      <= 1'b0;
            rd_cnt_q    <= '0;
            line_cnt_q  <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            line_full_q <= 1'b0;
            pf_full_q   <= 1'b0;
            line_q      <= '0;
            pf_q        <= '0;
        end else if (launch | zero_start) begin
            n_q         <= n_clamp;
            relu_q      <= relu_en;
            rd_cnt_q    <= '0;
            line_cnt_q  <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            line_full_q <= 1'b0;
            pf_full_q   <= 1'b0;
        end else begin
            pend_q <= issue;
            if (issue) rd_cnt_q <= rd_cnt_q + CW'(1);
            if (hs) begin
                beat_q <= line_end ? '0 : beat_q + BW'(1);
                if (line_end) line_cnt_q <= line_cnt_q + CW'(1);
            end
            if (pend_q && line_free) begin
                line_q      <= bram_read_data_flat;
                line_full_q <= 1'b1;
            end else if (pf_move) begin
                line_q    <= pf_q;
                pf_full_q <= 1'b0;
            end else if (line_end) begin
                line_full_q <= 1'b0;
            end
            if (pend_q && !line_free) begin
                pf_q      <= bram_read_data_flat;
                pf_full_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_output_drain_axis.sv
// tb_output_drain_axis: directed runs against a BRAM model with a
// scoreboard of expected beats.
module tb_output_drain_axis;
    localparam int DW    = 16;
    localparam int NB    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            relu_en = 1'b0;
    logic [AW:0]     num_words = '0;
    logic            ext_read_mode;
    logic [NB*AW-1:0] addr_flat;
    logic [NB-1:0]   ext_read_en;
    logic [NB*DW-1:0] rdata = '0;
    logic            busy, done;

    output_drain_axis_if #(.DW(DW)) axis ();

    output_drain_axis #(
        .DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_words(num_words),
        .relu_en(relu_en),
        .ext_read_mode(ext_read_mode),
        .ext_read_addr_flat(addr_flat),
        .ext_read_en(ext_read_en),
        .bram_read_data_flat(rdata),
        .m_axis(axis),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [NB][DEPTH];

    // Banked BRAM: one-cycle read latency per bank.
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (ext_read_en[k])
                rdata[k*DW +: DW] <= mem[k][addr_flat[k*AW +: AW]];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [DW:0] sb [$];
    int  s, beats, pulses, first_beat, last_beat, first_pulse, done_rel;
    bit  mode_seen, hold_v, mon_en;
    logic [DW:0] hold;

    // Output monitor: scoreboard pops, hold stability, read pulses.
    always @(negedge clk) begin : mon
        logic [DW:0] e;
        if (rst_n && mon_en) begin
            if (hold_v) begin
                chk("hold_valid", axis.tvalid, 1);
                chk("hold_beat", {axis.tlast, axis.tdata}, hold);
            end
            hold_v = axis.tvalid && !axis.tready;
            hold   = {axis.tlast, axis.tdata};
            if (axis.tvalid && axis.tready) begin
                if (first_beat < 0) first_beat = cyc - s + 1;
                last_beat = cyc - s + 1;
                beats++;
                if (sb.size() == 0) begin
                    chk("extra_beat", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {axis.tlast, axis.tdata}, e);
                end
            end
            if (ext_read_en != '0) begin
                pulses++;
                if (first_pulse < 0) first_pulse = cyc - s + 1;
                chk("en_ones", ext_read_en, {NB{1'b1}});
                chk("rd_mode", ext_read_mode, 1);
                chk("rd_addr", addr_flat, {NB{AW'(pulses - 1)}});
            end
            if (ext_read_mode) mode_seen = 1'b1;
            if (done) done_rel = cyc - s + 1;
        end
    end

    function automatic bit rdy(input int pat, input int i);
        if (pat == 0) return 1'b1;
        if (i >= 40 && i < 60) return 1'b0;
        return (i % 4 == 0) || (i % 4 == 3);
    endfunction

    task automatic run(input int n, input bit relu, input int pat,
                       input int rst_at, input bit stray);
        int nc;
        logic [DW-1:0] d;
        bit fin;
        nc = (n > DEPTH) ? DEPTH : n;
        sb.delete();
        for (int a = 0; a < nc; a++)
            for (int b = 0; b < NB; b++) begin
                d = mem[b][a];
                if (relu && d[DW-1]) d = '0;
                sb.push_back({(a == nc - 1) && (b == NB - 1), d});
            end
        beats = 0; pulses = 0; first_beat = -1; last_beat = -1;
        first_pulse = -1; done_rel = -1; mode_seen = 0; hold_v = 0;
        start = 1'b1;
        num_words = (AW+1)'(n);
        relu_en = relu;
        axis.tready = rdy(pat, 0);
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        mon_en = 1'b1;
        fin = 1'b0;
        for (int i = 1; i < 12000 && !fin; i++) begin
            axis.tready = rdy(pat, i);
            start = stray && (i == 4);
            if (start) num_words = 3;
            if (rst_at > 0 && beats == rst_at - 1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tvalid", axis.tvalid, 0);
                chk("rst_tdata", axis.tdata, 0);
                chk("rst_tlast", axis.tlast, 0);
                chk("rst_mode", ext_read_mode, 0);
                chk("rst_en", ext_read_en, 0);
                chk("rst_addr", addr_flat, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                mon_en = 1'b0;
                hold_v = 1'b0;
                sb.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (done_rel >= 0) fin = 1'b1;
            end
        end
        start = 1'b0;
        if (rst_at == 0) begin
            chk("done_seen", done_rel >= 0, 1);
            chk("sb_drained", sb.size(), 0);
            chk("pulse_count", pulses, nc);
            chk("beat_count", beats, nc * NB);
        end
    endtask

    task automatic idle_chk();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_tvalid", axis.tvalid, 0);
        chk("idle_mode", ext_read_mode, 0);
        chk("idle_addr", addr_flat, 0);
        chk("idle_sb", sb.size(), 0);
    endtask

    logic [DW-1:0] rv [4];

    initial begin
        rv[0] = 16'hFFFB; rv[1] = 16'h8000; rv[2] = 16'h0000; rv[3] = 16'h0007;
        axis.tready = 1'b0;
        mon_en = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < NB; b++)
                mem[b][a] = DW'((a << 4) | b);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", axis.tvalid, 0);
        chk("reset_tdata", axis.tdata, 0);
        chk("reset_tlast", axis.tlast, 0);
        chk("reset_mode", ext_read_mode, 0);
        chk("reset_en", ext_read_en, 0);
        chk("reset_addr", addr_flat, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int b = 0; b < NB; b++) mem[b][0] = DW'(b + 1);
        run(1, 0, 0, 0, 0);
        chk("single_first_pulse", first_pulse, 1);
        chk("single_first_beat", first_beat, 3);
        chk("single_last_beat", last_beat, 18);
        chk("single_done", done_rel, 19);
        idle_chk();
        for (int b = 0; b < NB; b++) mem[b][0] = DW'(b);

        run(4, 0, 0, 0, 0);
        chk("four_first_beat", first_beat, 3);
        chk("four_no_bubble", last_beat - first_beat, 63);
        idle_chk();

        run(4, 0, 1, 0, 0);
        idle_chk();

        for (int b = 0; b < NB; b++) mem[b][0] = rv[b % 4];
        run(1, 1, 0, 0, 0);
        idle_chk();
        run(1, 0, 0, 0, 0);
        idle_chk();
        for (int b = 0; b < NB; b++) mem[b][0] = DW'(b);

        run(0, 0, 0, 0, 0);
        chk("zero_done", done_rel, 1);
        chk("zero_mode", mode_seen, 0);
        idle_chk();

        run(600, 0, 0, 0, 0);
        idle_chk();

        run(4, 0, 0, 30, 0);
        chk("rst_partial_beats", beats, 29);
        idle_chk();

        for (int b = 0; b < NB; b++) mem[b][0] = DW'(b + 1);
        run(1, 0, 0, 0, 1);
        chk("post_first_beat", first_beat, 3);
        chk("post_last_beat", last_beat, 18);
        chk("post_done", done_rel, 19);
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
